// File: rtl/dmem_store_responder_if.sv
// Store/load bus between the core datapath (master) and dmem_store_responder (slave).
//   MemWrite, MemRead, DataAdr, WriteData, DrainHold : core -> responder
//   ReadData, Stall, Pending, Done, Pass              : responder -> core
// DEPTH must match the DEPTH of the responder it is connected to.
interface dmem_store_responder_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     MemWrite;
  logic                     MemRead;
  logic [31:0]              DataAdr;
  logic [31:0]              WriteData;
  logic                     DrainHold;
  logic [31:0]              ReadData;
  logic                     Stall;
  logic [$clog2(DEPTH):0]   Pending;
  logic                     Done;
  logic                     Pass;

  modport master (
    output MemWrite, MemRead, DataAdr, WriteData, DrainHold,
    input  ReadData, Stall, Pending, Done, Pass
  );

  modport slave (
    input  MemWrite, MemRead, DataAdr, WriteData, DrainHold,
    output ReadData, Stall, Pending, Done, Pass
  );
endinterface

// File: rtl/dmem_store_responder.sv
// Data-memory store responder with a posted FIFO write buffer.
// Stores are queued and drained one per cycle into a word-addressed RAM whenever the single
// RAM port is not taken by a load (MemRead) and DrainHold is low. Loads are combinational and
// forward from the newest buffered store to the same word index.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - synchronous, active-high; discards buffered stores (RAM contents kept)
//   bus   - dmem_store_responder_if.slave (MemWrite/MemRead/DataAdr/WriteData/DrainHold in,
//           ReadData/Stall/Pending/Done/Pass out)
// Optional feature: define STORE_MONITOR_EN to enable the PASS_ADR/PASS_VAL store monitor
// driving Done/Pass; otherwise both are tied low.
module dmem_store_responder #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AW       = 6,
  parameter logic [31:0] PASS_ADR = 32'd100,
  parameter logic [31:0] PASS_VAL = 32'd25
) (
  input logic                   clk,
  input logic                   reset,
  dmem_store_responder_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] idx_q  [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   ram    [2**AW];
  // Extra wrap bit distinguishes full from empty.
  logic [PW:0]   head_q, tail_q;
  logic [PW:0]   pending;
  logic          full, empty, enq, drn;
  logic [AW-1:0] adr_idx;
  logic [AW-1:0] head_idx;
  logic [31:0]   head_data;
  logic [31:0]   rdata;
  logic [PW-1:0] slot;

  assign adr_idx   = bus.DataAdr[AW+1:2];
  assign pending   = tail_q - head_q;
  assign full      = (pending == (PW+1)'(DEPTH));
  assign empty     = (pending == '0);
  assign enq       = bus.MemWrite && !full;
  assign drn       = !empty && !bus.MemRead && !bus.DrainHold;
  assign head_idx  = idx_q[head_q[PW-1:0]];
  assign head_data = data_q[head_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (enq) tail_q <= tail_q + (PW+1)'(1);
      if (drn) head_q <= head_q + (PW+1)'(1);
    end
  end

  // Buffer payload and RAM are not reset; only the pointers qualify validity.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      idx_q[tail_q[PW-1:0]]  <= adr_idx;
      data_q[tail_q[PW-1:0]] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && drn) ram[head_idx] <= head_data;
  end

  // Walk valid entries oldest to newest so the last match (newest) wins.
  always_comb begin
    rdata = ram[adr_idx];
    slot  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head_q[PW-1:0] + PW'(i);
      if (((PW+1)'(i) < pending) && (idx_q[slot] == adr_idx)) rdata = data_q[slot];
    end
  end

  assign bus.ReadData = rdata;
  assign bus.Stall    = bus.MemWrite && full;
  assign bus.Pending  = pending;

  logic unused_adr;
  assign unused_adr = ^{bus.DataAdr[31:AW+2], bus.DataAdr[1:0]};

`ifdef STORE_MONITOR_EN
  logic done_q, pass_q;

  // Only the first accepted store to PASS_ADR is judged; the verdict is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else if (enq && !done_q && (bus.DataAdr == PASS_ADR)) begin
      done_q <= 1'b1;
      pass_q <= (bus.WriteData == PASS_VAL);
    end
  end

  assign bus.Done = done_q;
  assign bus.Pass = pass_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{PASS_ADR, PASS_VAL};
  assign bus.Done   = 1'b0;
  assign bus.Pass   = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_store_responder.sv
// Directed self-checking bench for dmem_store_responder (default parameters).
// Done/Pass expectations follow STORE_MONITOR_EN when the bench is built with it.
module tb_dmem_store_responder;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

`ifdef STORE_MONITOR_EN
  localparam logic Mon = 1'b1;
`else
  localparam logic Mon = 1'b0;
`endif

  dmem_store_responder_if #(.DEPTH(4)) bus ();

  dmem_store_responder #(
    .DEPTH(4),
    .AW(6),
    .PASS_ADR(32'd100),
    .PASS_VAL(32'd25)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.WriteData = '0;
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] val);
    bus.MemWrite  = 1'b1;
    bus.MemRead   = 1'b0;
    bus.DataAdr   = adr;
    bus.WriteData = val;
    step();
    idle();
    #1;
  endtask

  task automatic load(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b1;
    bus.DataAdr  = adr;
    #1;
    chk(tag, bus.ReadData, exp);
    bus.MemRead = 1'b0;
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.DrainHold = 1'b0;
    bus.DataAdr   = '0;
    idle();
    step();
    step();
    chk("rst_pending", 32'(bus.Pending), 32'd0);
    chk("rst_stall", 32'(bus.Stall), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_pass", 32'(bus.Pass), 32'd0);
    reset = 1'b0;

    // 1: store then forwarded load, then drain.
    store(32'd100, 32'd25);
    chk("t1_pending1", 32'(bus.Pending), 32'd1);
    load("t1_fwd", 32'd100, 32'd25);
    step();
    chk("t1_pending0", 32'(bus.Pending), 32'd0);
    load("t1_ram", 32'd100, 32'd25);
    chk("t1_done", 32'(bus.Done), 32'(Mon));
    chk("t1_pass", 32'(bus.Pass), 32'(Mon));

    // 2: fill buffer with drain held, stall on the 5th store, then drain in order.
    bus.DrainHold = 1'b1;
    store(32'd0, 32'd1);
    store(32'd4, 32'd2);
    store(32'd8, 32'd3);
    store(32'd12, 32'd4);
    chk("t2_full_pending", 32'(bus.Pending), 32'd4);
    chk("t2_nostall_idle", 32'(bus.Stall), 32'd0);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = 32'd16;
    bus.WriteData = 32'd5;
    #1;
    chk("t2_stall", 32'(bus.Stall), 32'd1);
    step();
    chk("t2_pending_stalled", 32'(bus.Pending), 32'd4);
    idle();
    bus.DrainHold = 1'b0;
    step();
    chk("t2_drain3", 32'(bus.Pending), 32'd3);
    step();
    chk("t2_drain2", 32'(bus.Pending), 32'd2);
    step();
    chk("t2_drain1", 32'(bus.Pending), 32'd1);
    step();
    chk("t2_drain0", 32'(bus.Pending), 32'd0);
    load("t2_ram0", 32'd0, 32'd1);
    load("t2_ram1", 32'd4, 32'd2);
    load("t2_ram2", 32'd8, 32'd3);
    load("t2_ram3", 32'd12, 32'd4);

    // 3: two stores to one index; newest forwards and ends in RAM.
    bus.DrainHold = 1'b1;
    store(32'd96, 32'd7);
    store(32'd96, 32'd9);
    load("t3_fwd_newest", 32'd96, 32'd9);
    bus.DrainHold = 1'b0;
    step();
    step();
    chk("t3_pending0", 32'(bus.Pending), 32'd0);
    load("t3_ram_newest", 32'd96, 32'd9);

    // 4: loads block drain; simultaneous store + drain keeps occupancy.
    bus.DrainHold = 1'b1;
    store(32'd20, 32'h20);
    store(32'd24, 32'h24);
    bus.DrainHold = 1'b0;
    bus.MemRead   = 1'b1;
    bus.DataAdr   = 32'd40;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_read_blocks", 32'(bus.Pending), 32'd2);
    end
    store(32'd28, 32'h28);
    chk("t4_enq_drain", 32'(bus.Pending), 32'd2);
    step();
    step();
    chk("t4_pending0", 32'(bus.Pending), 32'd0);
    load("t4_ram20", 32'd20, 32'h20);
    load("t4_ram28", 32'd28, 32'h28);

    // 5: reset discards undrained stores; RAM keeps old values.
    bus.DrainHold = 1'b1;
    store(32'd0, 32'haa);
    store(32'd4, 32'hbb);
    store(32'd8, 32'hcc);
    chk("t5_pending3", 32'(bus.Pending), 32'd3);
    load("t5_fwd", 32'd4, 32'hbb);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_pending", 32'(bus.Pending), 32'd0);
    load("t5_ram0", 32'd0, 32'd1);
    load("t5_ram1", 32'd4, 32'd2);
    load("t5_ram2", 32'd8, 32'd3);
    bus.DrainHold = 1'b0;
    chk("t5_done_cleared", 32'(bus.Done), 32'd0);

    // 6: store monitor (all-zero expectations when disabled).
    store(32'd96, 32'd10);
    store(32'd356, 32'd25);
    chk("t6_alias_ignored", 32'(bus.Done), 32'd0);
    store(32'd100, 32'd25);
    chk("t6_done", 32'(bus.Done), 32'(Mon));
    chk("t6_pass", 32'(bus.Pass), 32'(Mon));
    store(32'd100, 32'd7);
    chk("t6_pass_sticky", 32'(bus.Pass), 32'(Mon));
    reset = 1'b1;
    step();
    reset = 1'b0;
    store(32'd100, 32'd30);
    chk("t6_done_bad", 32'(bus.Done), 32'(Mon));
    chk("t6_pass_bad", 32'(bus.Pass), 32'd0);
    store(32'd100, 32'd25);
    chk("t6_fail_sticky", 32'(bus.Pass), 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
